dmem_dma_engine: RTL and testbench

//  Initiator-side DMA engine for the word-addressed data memory port (mem_read/mem_write/addr/write_data/read_data).

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_dma_engine.sv | 143 ++++++++++++++
 tb/tb_dmem_dma_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: geometry and DMA engine state encoding.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_WORDS  = 1 << DMEM_ADDR_W;
  localparam int DMA_LEN_W   = DMEM_ADDR_W + 1;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_RD   = 2'd1,
    DMA_WR   = 2'd2,
    DMA_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dmem_dma_engine.sv
// Initiator-side DMA engine: block COPY or FILL over the word-addressed
// data memory port, one access per granted cycle.
module dmem_dma_engine
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       fill_value,
  output logic              busy,
  output logic              done,
  input  logic              mem_grant,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  dma_state_e        r_state;
  logic              r_op_fill;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       r_fill_value;
  logic [31:0]       r_data_buf;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_read;
  logic              r_mem_write;

  logic [ADDR_W-1:0] w_src_inc;
  logic [ADDR_W-1:0] w_dst_inc;
  logic              w_last;

  // Increments wrap at 2**ADDR_W by construction of the width.
  assign w_src_inc = r_src + ADDR_W'(1);
  assign w_dst_inc = r_dst + ADDR_W'(1);
  assign w_last    = (r_rem == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= DMA_IDLE;
      r_op_fill    <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_rem        <= '0;
      r_fill_value <= '0;
      r_data_buf   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      unique case (r_state)
        DMA_IDLE: begin
          if (start) begin
            r_op_fill    <= op_fill;
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_rem        <= len;
            r_fill_value <= fill_value;
            r_busy       <= 1'b1;
            if (len == '0) begin
              r_state <= DMA_DONE;
              r_done  <= 1'b1;
            end else if (op_fill) begin
              r_state     <= DMA_WR;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= DMA_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        DMA_RD: begin
          if (mem_grant) begin
            r_data_buf  <= mem_rdata;
            r_state     <= DMA_WR;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b1;
          end
        end
        DMA_WR: begin
          if (mem_grant) begin
            r_dst <= w_dst_inc;
            r_rem <= r_rem - LEN_W'(1);
            if (!r_op_fill) begin
              r_src <= w_src_inc;
            end
            if (w_last) begin
              r_state     <= DMA_DONE;
              r_done      <= 1'b1;
              r_mem_write <= 1'b0;
            end else if (!r_op_fill) begin
              r_state     <= DMA_RD;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
            end
          end
        end
        DMA_DONE: begin
          r_state <= DMA_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

  // Address and data are steered straight from the held registers so a
  // stalled access presents identical values until it is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      DMA_RD: begin
        mem_addr = {{(32-ADDR_W){1'b0}}, r_src};
      end
      DMA_WR: begin
        mem_addr  = {{(32-ADDR_W){1'b0}}, r_dst};
        mem_wdata = r_op_fill ? r_fill_value : r_data_buf;
      end
      DMA_IDLE, DMA_DONE: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Self-checking bench for dmem_dma_engine: vector table plus write
// scoreboard against a shadow memory model.
module tb_dmem_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_fill;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] len;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        mem_grant;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem   [1024];
  logic [31:0] model [1024];

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    logic        fill;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic [10:0] len;
    logic [31:0] val;
    logic [63:0] glow;
    logic        poke;
    int          exp_done;
    string       nm;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  dmem_dma_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_fill    (op_fill),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .mem_grant  (mem_grant),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && mem_grant) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Write monitor: every granted write must match the scoreboard head.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      chk("strobe_excl", {31'b0, mem_read && mem_write}, 32'h0);
      chk("addr_hi", {10'b0, mem_addr[31:10]}, 32'h0);
    end
    if (mem_write && mem_grant) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        chk("wr_addr", mem_addr, {22'b0, e.a});
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic mem_cmp(input string nm);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== model[i]) bad++;
    end
    chk(nm, 32'(bad), 32'h0);
  endtask

  task automatic run(input vec_t v);
    int cyc;
    int done_cyc = 0;
    int busy_n   = 0;
    int strobe_n = 0;
    int held_n   = 0;
    int first_busy = 0;
    for (int i = 0; i < int'(v.len); i++) begin
      logic [9:0]  a;
      logic [9:0]  s;
      logic [31:0] d;
      a = v.dst + 10'(i);
      s = v.src + 10'(i);
      d = v.fill ? v.val : model[s];
      model[a] = d;
      sbq.push_back('{a, d});
    end
    @(negedge clk);
    start      = 1'b1;
    op_fill    = v.fill;
    src_addr   = v.src;
    dst_addr   = v.dst;
    len        = v.len;
    fill_value = v.val;
    mem_grant  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (done_cyc == 0 && cyc < 3000) begin
      mem_grant = (cyc < 64) ? !v.glow[cyc] : 1'b1;
      if (v.poke && cyc == 3) begin
        start      = 1'b1;
        op_fill    = 1'b1;
        dst_addr   = 10'd200;
        len        = 11'd1;
        fill_value = 32'hBAD0BAD0;
      end else if (v.poke && cyc == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (first_busy == 0) first_busy = cyc;
      end
      if (mem_read || mem_write) strobe_n++;
      if (!mem_grant && (mem_read || mem_write)) held_n++;
      if (done) done_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    start     = 1'b0;
    mem_grant = 1'b1;
    chk({"done_cyc_", v.nm}, 32'(done_cyc), 32'(v.exp_done));
    chk({"busy_cycles_", v.nm}, 32'(busy_n), 32'(v.exp_done));
    chk({"busy_first_", v.nm}, 32'(first_busy), 32'd1);
    chk({"strobe_cycles_", v.nm}, 32'(strobe_n),
        (v.len == 0) ? 32'd0 : 32'(v.exp_done - 1));
    chk({"stall_held_", v.nm}, 32'(held_n), 32'($countones(v.glow)));
    chk({"busy_after_", v.nm}, {31'b0, busy}, 32'h0);
    chk({"sb_empty_", v.nm}, 32'(sbq.size()), 32'h0);
    mem_cmp({"mem_", v.nm});
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    op_fill    = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    fill_value = '0;
    mem_grant  = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(i);
      case (i)
        0: w = 32'd4;
        1: w = 32'd3;
        2: w = 32'd5;
        3: w = 32'd1;
        4: w = 32'd2;
        5: w = 32'd6;
        6: w = 32'd7;
        default: ;
      endcase
      mem[i]   <= w;
      model[i] = w;
    end

    vt[0] = '{1'b0, 10'd0,    10'd16,   11'd3, 32'h0,        64'h0,
              1'b0, 7,  "copy3"};
    vt[1] = '{1'b1, 10'd0,    10'd100,  11'd4, 32'hDEADBEEF, 64'h0,
              1'b0, 5,  "fill4"};
    vt[2] = '{1'b0, 10'd5,    10'd50,   11'd0, 32'h0,        64'h0,
              1'b0, 1,  "len0"};
    vt[3] = '{1'b0, 10'd0,    10'd32,   11'd5, 32'h0,
              64'h0000_0000_0000_1838, 1'b0, 16, "stall"};
    vt[4] = '{1'b0, 10'd2,    10'd40,   11'd2, 32'h0,        64'h0,
              1'b1, 5,  "start_busy"};
    vt[5] = '{1'b0, 10'd1020, 10'd1022, 11'd4, 32'h0,        64'h0,
              1'b0, 9,  "wrap"};

    #1;
    chk("rst_busy",  {31'b0, busy},      32'h0);
    chk("rst_done",  {31'b0, done},      32'h0);
    chk("rst_rd",    {31'b0, mem_read},  32'h0);
    chk("rst_wr",    {31'b0, mem_write}, 32'h0);
    chk("rst_addr",  mem_addr,           32'h0);
    chk("rst_wdata", mem_wdata,          32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run(vt[k]);

    // Reset during the third write of a 6-word FILL.
    for (int i = 0; i < 6; i++) begin
      logic [9:0] a;
      a = 10'd300 + 10'(i);
      if (i < 2) model[a] = 32'hA5A5_5A5A;
      sbq.push_back('{a, 32'hA5A5_5A5A});
    end
    @(negedge clk);
    start      = 1'b1;
    op_fill    = 1'b1;
    dst_addr   = 10'd300;
    len        = 11'd6;
    fill_value = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy",  {31'b0, busy},      32'h0);
    chk("abort_done",  {31'b0, done},      32'h0);
    chk("abort_wr",    {31'b0, mem_write}, 32'h0);
    chk("abort_rd",    {31'b0, mem_read},  32'h0);
    chk("abort_addr",  mem_addr,           32'h0);
    chk("abort_wdata", mem_wdata,          32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'h0);
    end
    chk("abort_left", 32'(sbq.size()), 32'd4);
    sbq.delete();
    mem_cmp("mem_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
